bitplane_frame_tx: RTL and testbench

- Parametrised serial bit-plane transmitter.
- On a start pulse it reads ROWS words once from the read-only register bank and buffers them.
- It then emits one serial frame per bit column on sen/sd. Each frame carries a column-index header followed by that column's bit from every row.
- Sits between the register bank and the downstream serial receiver. Adds a start/done handshake, a row-order mode, a column-order mode and a configurable inter-frame gap.

---
 rtl/bitplane_frame_tx.sv | 104 ++++++++++
 tb/tb_bitplane_frame_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitplane_frame_tx.sv
// bitplane_frame_tx: loads ROWS bank words, then sends one serial frame per bit column
// (column-index header, then that column's bit from every row) with gaps between frames.
module bitplane_frame_tx #(
    parameter int ROWS   = 18,
    parameter int WORD_W = 8,
    parameter int RB_AW  = 5,
    parameter int HDR_W  = 3,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              row_rev,
    input  logic              col_rev,
    output logic              busy,
    output logic              done,
    output logic              RB_RW,
    output logic [RB_AW-1:0]  RB_A,
    output logic [WORD_W-1:0] RB_D,
    input  logic [WORD_W-1:0] RB_Q,
    output logic              sen,
    output logic              sd
);
    localparam int FW = HDR_W + ROWS;
    localparam int CM = FW > GAP ? FW : GAP;
    localparam int CW = $clog2(CM + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

    state_t             st, nxt;
    logic [CW-1:0]      cnt;
    logic [HDR_W:0]     fcnt;
    logic [HDR_W-1:0]   col;
    logic               rrev, crev, cap;
    logic [FW-1:0]      sh;
    logic [ROWS-1:0]    d;
    logic [WORD_W-1:0]  rows_q [ROWS];
    logic [WORD_W-1:0]  rows_n [ROWS];

    always_comb begin
        nxt = st;
        case (st)
            S_IDLE: if (start && !done) nxt = S_LOAD;
            S_LOAD: if (cnt == CW'(ROWS)) nxt = S_SEND;
            S_SEND: if (cnt == CW'(FW - 1)) nxt = S_GAP;
            S_GAP:  if (cnt == CW'(GAP - 1)) nxt = (fcnt == (HDR_W+1)'(WORD_W)) ? S_IDLE : S_SEND;
            default: nxt = S_IDLE;
        endcase
    end

    // Words arrive in address order and shift down, so row 0 ends at index 0.
    // The frame shifter reads rows_n so the first frame sees the final capture.
    assign cap = (st == S_LOAD) && (cnt != '0);

    always_comb begin
        rows_n = rows_q;
        if (cap) begin
            for (int r = 0; r < ROWS - 1; r++) rows_n[r] = rows_q[r+1];
            rows_n[ROWS-1] = RB_Q;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_col
        assign d[r] = rrev ? rows_n[ROWS-1-r][col] : rows_n[r][col];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st   <= S_IDLE;
            done <= 1'b0;
            cnt  <= '0;
            fcnt <= '0;
            col  <= '0;
            rrev <= 1'b0;
            crev <= 1'b0;
            sh   <= '0;
            for (int r = 0; r < ROWS; r++) rows_q[r] <= '0;
        end else begin
            st     <= nxt;
            done   <= (st == S_GAP) && (nxt == S_IDLE);
            cnt    <= (nxt != st) ? '0 : cnt + 1'b1;
            rows_q <= rows_n;
            if (st == S_IDLE && nxt == S_LOAD) begin
                rrev <= row_rev;
                crev <= col_rev;
                col  <= col_rev ? '0 : '1;
                fcnt <= '0;
            end
            if (nxt == S_SEND && st != S_SEND) sh <= {col, d};
            else if (st == S_SEND) sh <= sh << 1;
            if (st == S_SEND && nxt == S_GAP) begin
                col  <= crev ? col + 1'b1 : col - 1'b1;
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign busy  = st != S_IDLE;
    assign sen   = st != S_SEND;
    assign sd    = (st == S_SEND) && sh[FW-1];
    assign RB_A  = (st == S_LOAD && cnt < CW'(ROWS)) ? RB_AW'(cnt) : '0;
    assign RB_RW = 1'b1;
    assign RB_D  = '0;
endmodule

// File: tb/tb_bitplane_frame_tx.sv
// tb_bitplane_frame_tx: two configurations checked against a frame-level reference model.
module tb_bitplane_frame_tx;
    localparam int R1 = 18, W1 = 8, H1 = 3, G1 = 1;
    localparam int R2 = 4,  W2 = 4, H2 = 2, G2 = 3;

    logic clk = 0, rst = 0;
    logic start_a = 0, start_b = 0, row_rev = 0, col_rev = 0;
    logic busy_a, done_a, rw_a, sen_a, sd_a, busy_b, done_b, rw_b, sen_b, sd_b;
    logic [4:0] a_a;
    logic [2:0] a_b;
    logic [7:0] d_a, q_a;
    logic [3:0] d_b, q_b;
    logic [7:0] bank_a [32];
    logic [3:0] bank_b [8];
    logic [31:0] obs [8];
    int sel = 0, vecs = 0, errs = 0;
    logic sen_m, sd_m, busy_m, done_m;

    always #5 clk = ~clk;

    bitplane_frame_tx #(.ROWS(R1), .WORD_W(W1), .RB_AW(5), .HDR_W(H1), .GAP(G1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .row_rev(row_rev), .col_rev(col_rev),
        .busy(busy_a), .done(done_a), .RB_RW(rw_a), .RB_A(a_a), .RB_D(d_a), .RB_Q(q_a),
        .sen(sen_a), .sd(sd_a));

    bitplane_frame_tx #(.ROWS(R2), .WORD_W(W2), .RB_AW(3), .HDR_W(H2), .GAP(G2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .row_rev(row_rev), .col_rev(col_rev),
        .busy(busy_b), .done(done_b), .RB_RW(rw_b), .RB_A(a_b), .RB_D(d_b), .RB_Q(q_b),
        .sen(sen_b), .sd(sd_b));

    always @(posedge clk) begin
        q_a <= bank_a[a_a];
        q_b <= bank_b[a_b];
    end

    assign sen_m  = sel != 0 ? sen_b  : sen_a;
    assign sd_m   = sel != 0 ? sd_b   : sd_a;
    assign busy_m = sel != 0 ? busy_b : busy_a;
    assign done_m = sel != 0 ? done_b : done_a;

    function automatic logic [31:0] exp_frame(int f, bit rr, bit cr);
        int rows = sel != 0 ? R2 : R1;
        int ww   = sel != 0 ? W2 : W1;
        int hw   = sel != 0 ? H2 : H1;
        int col  = cr ? f : ww - 1 - f;
        int row, w;
        logic [31:0] v = '0;
        for (int i = hw - 1; i >= 0; i--) v = (v << 1) | 32'((col >> i) & 1);
        for (int i = 0; i < rows; i++) begin
            row = rr ? i : rows - 1 - i;
            w = sel != 0 ? int'(bank_b[row]) : int'(bank_a[row]);
            v = (v << 1) | 32'((w >> col) & 1);
        end
        return v;
    endfunction

    task automatic set_start(input logic v);
        if (sel != 0) start_b = v;
        else start_a = v;
    endtask

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic run_op(input bit rr, input bit cr, input bit jam);
        int rows = sel != 0 ? R2 : R1;
        int ww   = sel != 0 ? W2 : W1;
        int hw   = sel != 0 ? H2 : H1;
        int gp   = sel != 0 ? G2 : G1;
        int f = 0, len = 0, gap = 0, cyc = 0;
        logic [31:0] v = '0, e;
        bit in_frame = 0, fin = 0;
        row_rev = rr;
        col_rev = cr;
        set_start(1);
        @(negedge clk);
        set_start(0);
        for (int t = 0; t < 600 && !fin; t++) begin
            if (t > 0) @(negedge clk);
            row_rev = 1'($urandom);
            col_rev = 1'($urandom);
            set_start(jam && (t == 3 || t == rows + 10));
            if (done_m) begin
                fin = 1;
                vecs++;
                if (busy_m !== 1'b0) begin errs++; $display("FAIL busy_at_done: got %b want 0", busy_m); end
                vecs++;
                if (cyc != rows + 1 + ww * (hw + rows + gp)) begin
                    errs++; $display("FAIL busy_len: got %0d want %0d", cyc, rows + 1 + ww * (hw + rows + gp));
                end
                vecs++;
                if (f != ww) begin errs++; $display("FAIL frame_count: got %0d want %0d", f, ww); end
                vecs++;
                if (gap != gp) begin errs++; $display("FAIL trail_gap: got %0d want %0d", gap, gp); end
                set_start(1);
            end else begin
                if (busy_m) cyc++;
                if (!sen_m) begin
                    if (!in_frame) begin
                        if (f > 0) begin
                            vecs++;
                            if (gap != gp) begin errs++; $display("FAIL gap%0d: got %0d want %0d", f, gap, gp); end
                        end
                        in_frame = 1;
                        len = 0;
                        v = '0;
                    end
                    v = (v << 1) | 32'(sd_m);
                    len++;
                end else begin
                    if (in_frame) begin
                        in_frame = 0;
                        e = exp_frame(f, rr, cr);
                        vecs++;
                        if (len != hw + rows || v !== e) begin
                            errs++;
                            $display("FAIL frame%0d: got %h len %0d want %h len %0d", f, v, len, e, hw + rows);
                        end
                        if (f < 8) obs[f] = v;
                        f++;
                        gap = 0;
                    end
                    if (f > 0) gap++;
                    vecs++;
                    if (sd_m !== 1'b0) begin errs++; $display("FAIL sd_idle: got %b want 0", sd_m); end
                end
            end
        end
        if (!fin) begin
            errs++;
            $display("FAIL done_timeout: got no done want done within 600 cycles");
        end
        @(negedge clk);
        set_start(0);
        vecs++;
        if (done_m !== 1'b0 || busy_m !== 1'b0) begin
            errs++; $display("FAIL after_done: got done=%b busy=%b want 0 0", done_m, busy_m);
        end
    endtask

    task automatic check_idle(input string tag);
        vecs++;
        if ({sen_a, sd_a, busy_a, done_a, a_a, rw_a, d_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 8'd0}) begin
            errs++;
            $display("FAIL %s: got sen=%b sd=%b busy=%b done=%b A=%0d rw=%b D=%h want 1 0 0 0 0 1 00",
                     tag, sen_a, sd_a, busy_a, done_a, a_a, rw_a, d_a);
        end
    endtask

    task automatic test_reset;
        sel = 0;
        for (int k = 0; k < 32; k++) bank_a[k] = 8'($urandom);
        repeat (2) @(negedge clk);
        check_idle("reset_state");
        rst = 1;
        @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        repeat (30) @(negedge clk);
        vecs++;
        if (sen_a !== 1'b0) begin errs++; $display("FAIL mid_send: got sen=%b want 0", sen_a); end
        rst = 0;
        #1;
        check_idle("async_reset");
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check_idle("after_release");
        run_op(0, 0, 0);
    endtask

    task automatic test_bank_k;
        sel = 0;
        for (int k = 0; k < 32; k++) bank_a[k] = 8'(k);
        run_op(0, 0, 0);
        vecs++;
        if (obs[0] !== 32'h001C_0000) begin errs++; $display("FAIL k_col7: got %h want 001c0000", obs[0]); end
        vecs++;
        if (obs[3] !== 32'h0013_0000) begin errs++; $display("FAIL k_col4: got %h want 00130000", obs[3]); end
        run_op(1, 0, 0);
        vecs++;
        if (obs[3] !== 32'h0010_0003) begin errs++; $display("FAIL k_col4_rev: got %h want 00100003", obs[3]); end
        run_op(0, 1, 0);
        for (int f = 0; f < 8; f++) begin
            vecs++;
            if (obs[f][20:18] !== 3'(f)) begin errs++; $display("FAIL hdr_colrev%0d: got %0d want %0d", f, obs[f][20:18], f); end
        end
    endtask

    task automatic test_all_ones;
        sel = 0;
        for (int k = 0; k < 32; k++) bank_a[k] = 8'hFF;
        run_op(0, 0, 0);
        for (int f = 0; f < 8; f++) begin
            vecs++;
            if (obs[f] !== {11'd0, 3'(7 - f), 18'h3FFFF}) begin
                errs++; $display("FAIL ones%0d: got %h want %h", f, obs[f], {11'd0, 3'(7 - f), 18'h3FFFF});
            end
        end
    endtask

    task automatic test_jam;
        sel = 0;
        for (int k = 0; k < 32; k++) bank_a[k] = 8'($urandom);
        run_op(1'($urandom), 1'($urandom), 1);
        sel = 1;
        for (int k = 0; k < 8; k++) bank_b[k] = 4'($urandom);
        run_op(1'($urandom), 1'($urandom), 1);
    endtask

    task automatic test_back_to_back;
        sel = 0;
        for (int k = 0; k < 32; k++) bank_a[k] = 8'($urandom);
        run_op(0, 1, 0);
        run_op(0, 1, 0);
    endtask

    task automatic test_small;
        sel = 1;
        bank_b[0] = 4'h1; bank_b[1] = 4'h2; bank_b[2] = 4'h4; bank_b[3] = 4'h8;
        run_op(0, 0, 0);
        vecs++;
        if (obs[0] !== 32'h38) begin errs++; $display("FAIL small_col3: got %h want 38", obs[0]); end
        vecs++;
        if (obs[3] !== 32'h01) begin errs++; $display("FAIL small_col0: got %h want 01", obs[3]); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 4; n++) begin
            sel = 0;
            for (int k = 0; k < 32; k++) bank_a[k] = 8'($urandom);
            run_op(1'($urandom), 1'($urandom), 0);
            sel = 1;
            for (int k = 0; k < 8; k++) bank_b[k] = 4'($urandom);
            run_op(1'($urandom), 1'($urandom), 0);
        end
    endtask

    initial begin
        test_reset;
        test_bank_k;
        test_all_ones;
        test_jam;
        test_back_to_back;
        test_small;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
